// File: rtl/i2c_slave.sv
// I2C target for 7-bit addressed single-master transfers; SCL/SDA oversampled in clk domain.
// Open-drain SDA: only ever driven low or released, never clock-stretches.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       arstn,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] tx_data,
  output logic       tx_load,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rw,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WRITE, WR_ACK, READ, RD_ACK, WAIT_STOP
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] scl_p, sda_p;           // [1:0] synchronizer, [2] history
  logic [7:0] shreg, shreg_nxt;
  logic [3:0] bit_cnt, bit_cnt_nxt;
  logic       sda_oe, sda_oe_nxt;
  logic [7:0] rx_data_nxt;
  logic       rx_valid_nxt, tx_load_nxt, rw_nxt, busy_nxt;

  assign sda = sda_oe ? 1'b0 : 1'bz;

  // Idle-high reset keeps the bus-event detectors quiet after reset.
  always_ff @(posedge clk or negedge arstn)
    if (!arstn) begin
      scl_p <= 3'b111;
      sda_p <= 3'b111;
    end else begin
      scl_p <= {scl_p[1:0], scl};
      sda_p <= {sda_p[1:0], sda};
    end

  logic       scl_rise, scl_fall, start_c, stop_c, sda_in;
  logic [7:0] byte_in;
  assign scl_rise = scl_p[1] & ~scl_p[2];
  assign scl_fall = ~scl_p[1] & scl_p[2];
  assign start_c  = scl_p[1] & scl_p[2] & ~sda_p[1] & sda_p[2];
  assign stop_c   = scl_p[1] & scl_p[2] & sda_p[1] & ~sda_p[2];
  assign sda_in   = sda_p[1];
  assign byte_in  = {shreg[6:0], sda_in};

  always_ff @(posedge clk or negedge arstn)
    if (!arstn) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    if (start_c)     state_nxt = ADDR;
    else if (stop_c) state_nxt = IDLE;
    else
      case (state)
        ADDR:     if (scl_rise && bit_cnt == 4'd7)
                    state_nxt = (byte_in[7:1] == SLAVE_ADDR) ? ADDR_ACK : IDLE;
        ADDR_ACK: if (scl_fall && bit_cnt == 4'd1) state_nxt = rw ? READ : WRITE;
        WRITE:    if (scl_rise && bit_cnt == 4'd7) state_nxt = WR_ACK;
        WR_ACK:   if (scl_fall && bit_cnt == 4'd1) state_nxt = WRITE;
        READ:     if (scl_fall && bit_cnt == 4'd7) state_nxt = RD_ACK;
        RD_ACK:   if (scl_rise && sda_in)          state_nxt = WAIT_STOP;
                  else if (scl_fall && bit_cnt == 4'd1) state_nxt = READ;
        default:  state_nxt = state;
      endcase
  end

  always_comb begin
    shreg_nxt    = shreg;
    bit_cnt_nxt  = bit_cnt;
    sda_oe_nxt   = sda_oe;
    rx_data_nxt  = rx_data;
    rx_valid_nxt = 1'b0;
    tx_load_nxt  = 1'b0;
    rw_nxt       = rw;
    busy_nxt     = busy;
    if (start_c) sda_oe_nxt = 1'b0;
    else if (stop_c) begin
      sda_oe_nxt = 1'b0;
      busy_nxt   = 1'b0;
    end else
      case (state)
        ADDR: if (scl_rise) begin
          shreg_nxt   = byte_in;
          bit_cnt_nxt = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            if (byte_in[7:1] == SLAVE_ADDR) begin
              rw_nxt   = byte_in[0];
              busy_nxt = 1'b1;
            end else busy_nxt = 1'b0;
          end
        end
        // bit_cnt 0 -> 1 marks the ACK slot as entered; the second fall ends it.
        ADDR_ACK, WR_ACK: if (scl_fall) begin
          if (bit_cnt == 4'd0) begin
            sda_oe_nxt  = 1'b1;
            bit_cnt_nxt = 4'd1;
          end else if (state == ADDR_ACK && rw) begin
            tx_load_nxt = 1'b1;
            shreg_nxt   = tx_data;
            sda_oe_nxt  = ~tx_data[7];
          end else sda_oe_nxt = 1'b0;
        end
        WRITE: if (scl_rise) begin
          shreg_nxt   = byte_in;
          bit_cnt_nxt = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            rx_data_nxt  = byte_in;
            rx_valid_nxt = 1'b1;
          end
        end
        READ: if (scl_fall) begin
          if (bit_cnt == 4'd7) sda_oe_nxt = 1'b0;
          else begin
            shreg_nxt   = {shreg[6:0], 1'b0};
            sda_oe_nxt  = ~shreg[6];
            bit_cnt_nxt = bit_cnt + 4'd1;
          end
        end
        RD_ACK:
          if (scl_rise && !sda_in) bit_cnt_nxt = 4'd1;
          else if (scl_fall && bit_cnt == 4'd1) begin
            tx_load_nxt = 1'b1;
            shreg_nxt   = tx_data;
            sda_oe_nxt  = ~tx_data[7];
          end
        default: ;
      endcase
    if (start_c || state_nxt != state) bit_cnt_nxt = 4'd0;
  end

  always_ff @(posedge clk or negedge arstn)
    if (!arstn) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      sda_oe   <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      tx_load  <= 1'b0;
      rw       <= 1'b0;
      busy     <= 1'b0;
    end else begin
      shreg    <= shreg_nxt;
      bit_cnt  <= bit_cnt_nxt;
      sda_oe   <= sda_oe_nxt;
      rx_data  <= rx_data_nxt;
      rx_valid <= rx_valid_nxt;
      tx_load  <= tx_load_nxt;
      rw       <= rw_nxt;
      busy     <= busy_nxt;
    end

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-banged I2C master, table of whole transfers plus corner sequences.
module tb_i2c_slave;
  localparam int Q = 8;  // clk per quarter SCL period

  logic       clk = 1'b0, arstn = 1'b0, scl = 1'b1, m_drv = 1'b0;
  logic [7:0] tx_data = 8'h00;
  wire        sda;
  logic       tx_load, rx_valid, rw, busy;
  logic [7:0] rx_data;

  assign sda = m_drv ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 clk = ~clk;

  i2c_slave #(.SLAVE_ADDR(7'h50)) dut (
    .clk(clk), .arstn(arstn), .scl(scl), .sda(sda), .tx_data(tx_data),
    .tx_load(tx_load), .rx_data(rx_data), .rx_valid(rx_valid), .rw(rw), .busy(busy)
  );

  int n_tests = 0, n_fail = 0;
  int rxv_cnt = 0, txl_cnt = 0, drove_cnt = 0, ov_cnt = 0;

  always @(negedge clk) begin
    if (rx_valid) rxv_cnt <= rxv_cnt + 1;
    if (tx_load) txl_cnt <= txl_cnt + 1;
    if (rx_valid && tx_load) ov_cnt <= ov_cnt + 1;
    if (!m_drv && sda === 1'b0) drove_cnt <= drove_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic qw;
    repeat (Q) @(negedge clk);
  endtask

  // Works from idle (scl high) and as a repeated START (scl low).
  task automatic i2c_start;
    m_drv = 1'b0; qw;
    scl = 1'b1; qw;
    m_drv = 1'b1; qw;
    scl = 1'b0; qw;
  endtask

  task automatic i2c_stop;
    m_drv = 1'b1; qw;
    scl = 1'b1; qw;
    m_drv = 1'b0; qw; qw;
  endtask

  task automatic bit_out(input logic b, output logic s);
    m_drv = !b; qw;
    scl = 1'b1; qw;
    s = sda; qw;
    scl = 1'b0; qw;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_out(b[i], s);
    bit_out(1'b1, ack);
  endtask

  task automatic read_byte(input logic nack, input logic [7:0] nxt, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_out(1'b1, s);
      d[i] = s;
    end
    tx_data = nxt;
    bit_out(nack, s);
  endtask

  typedef struct {
    bit         rd;
    logic [7:0] addr;
    logic [7:0] dat;
    logic       exp_ack;     // sampled SDA in address ACK slot (0 = acked)
    logic [7:0] exp_byte;    // byte read back, or rx_data after a write/mismatch
    int         exp_pulses;  // tx_load pulses for reads, rx_valid pulses for writes
    logic       exp_rw;
  } vec_t;

  vec_t vt[8];

  initial begin
    logic       a;
    logic [7:0] d;
    int         rx0, tx0, dr0;

    vt[0] = '{1'b0, 8'hA0, 8'hA5, 1'b0, 8'hA5, 1, 1'b0};
    vt[1] = '{1'b1, 8'hA1, 8'h3C, 1'b0, 8'h3C, 1, 1'b1};
    vt[2] = '{1'b0, 8'hA2, 8'hA5, 1'b1, 8'hA5, 0, 1'b1};
    vt[3] = '{1'b0, 8'hA0, 8'h00, 1'b0, 8'h00, 1, 1'b0};
    vt[4] = '{1'b1, 8'hA1, 8'h81, 1'b0, 8'h81, 1, 1'b1};
    vt[5] = '{1'b0, 8'hA0, 8'hFF, 1'b0, 8'hFF, 1, 1'b0};
    vt[6] = '{1'b1, 8'h21, 8'h55, 1'b1, 8'hFF, 0, 1'b0};
    vt[7] = '{1'b1, 8'hA1, 8'h5A, 1'b0, 8'h5A, 1, 1'b1};

    repeat (4) @(negedge clk);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_tx_load", tx_load, 1'b0);
    check("rst_rw", rw, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_sda", sda, 1'b1);
    arstn = 1'b1;
    qw;

    for (int i = 0; i < 8; i++) begin
      rx0 = rxv_cnt; tx0 = txl_cnt; dr0 = drove_cnt;
      tx_data = vt[i].dat;
      i2c_start;
      write_byte(vt[i].addr, a);
      check($sformatf("v%0d_addr_ack", i), a, vt[i].exp_ack);
      check($sformatf("v%0d_busy", i), busy, !vt[i].exp_ack);
      d = rx_data;
      if (!vt[i].exp_ack) begin
        if (vt[i].rd) begin
          read_byte(1'b1, 8'h00, d);
          check($sformatf("v%0d_rd_release", i), sda, 1'b1);
        end else begin
          write_byte(vt[i].dat, a);
          check($sformatf("v%0d_data_ack", i), a, 1'b0);
          d = rx_data;
        end
      end else
        check($sformatf("v%0d_never_drove", i), drove_cnt - dr0, 0);
      i2c_stop;
      check($sformatf("v%0d_byte", i), d, vt[i].exp_byte);
      check($sformatf("v%0d_pulses", i),
            vt[i].rd ? txl_cnt - tx0 : rxv_cnt - rx0, vt[i].exp_pulses);
      if (vt[i].exp_ack) check($sformatf("v%0d_no_rx", i), rxv_cnt - rx0, 0);
      check($sformatf("v%0d_rw", i), rw, vt[i].exp_rw);
      check($sformatf("v%0d_busy_end", i), busy, 1'b0);
    end

    // Write then repeated START into a two-byte read.
    rx0 = rxv_cnt; tx0 = txl_cnt;
    tx_data = 8'h22;
    i2c_start;
    write_byte(8'hA0, a); check("sr_addr_ack", a, 1'b0);
    write_byte(8'h11, a); check("sr_data_ack", a, 1'b0);
    i2c_start;
    write_byte(8'hA1, a); check("sr_raddr_ack", a, 1'b0);
    read_byte(1'b0, 8'h33, d); check("sr_byte0", d, 8'h22);
    read_byte(1'b1, 8'h00, d); check("sr_byte1", d, 8'h33);
    i2c_stop;
    check("sr_rx_data", rx_data, 8'h11);
    check("sr_rw", rw, 1'b1);
    check("sr_rx_pulses", rxv_cnt - rx0, 1);
    check("sr_tx_pulses", txl_cnt - tx0, 2);
    check("sr_busy_end", busy, 1'b0);

    // STOP after four data bits of a write.
    rx0 = rxv_cnt;
    i2c_start;
    write_byte(8'hA0, a); check("ps_addr_ack", a, 1'b0);
    bit_out(1'b1, a); bit_out(1'b0, a); bit_out(1'b1, a); bit_out(1'b1, a);
    i2c_stop;
    check("ps_no_rx", rxv_cnt - rx0, 0);
    check("ps_rx_data", rx_data, 8'h11);
    check("ps_busy", busy, 1'b0);
    check("ps_sda", sda, 1'b1);

    // Reset while the target is driving a 0 data bit.
    tx_data = 8'h00;
    i2c_start;
    write_byte(8'hA1, a); check("ar_addr_ack", a, 1'b0);
    check("ar_driving", sda, 1'b0);
    check("ar_busy", busy, 1'b1);
    arstn = 1'b0;
    #1;
    check("ar_sda", sda, 1'b1);
    check("ar_busy_rst", busy, 1'b0);
    check("ar_rw", rw, 1'b0);
    check("ar_rx_data", rx_data, 8'h00);
    check("ar_rx_valid", rx_valid, 1'b0);
    check("ar_tx_load", tx_load, 1'b0);
    scl = 1'b1; qw;
    arstn = 1'b1; qw;

    check("no_overlap", ov_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
